// File: rtl/sram_ctrl.sv
// Request front-end for the single-port SRAM: an in-order command queue feeding
// registered WE/RD/Addr/dataIn pulses, with read data returned as one-cycle responses.
module sram_ctrl #(
  parameter  int DAT    = 4,
  parameter  int DPTH   = 4,
  parameter  int QDEPTH = 4,
  localparam int ADDR_W = $clog2(DPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DAT-1:0]    req_data,
  output logic              rsp_valid,
  output logic [DAT-1:0]    rsp_data,
  output logic              busy,
  output logic [DAT-1:0]    sram_din,
  input  logic [DAT-1:0]    sram_dout,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic              sram_rd
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DAT-1:0]    data;
  } req_t;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP} state_t;

  req_t          q_mem [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  req_t          head;

  state_t            state, state_nxt;
  logic              we_nxt, rd_nxt, rsp_valid_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DAT-1:0]    din_nxt, rsp_data_nxt;

  assign req_ready = !rst && (count < CW'(QDEPTH));
  assign push      = req_valid && req_ready;
  assign head      = q_mem[rd_ptr];
  assign busy      = (count != '0) || (state != IDLE);

  // NOTE: queue storage carries no reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= '{wr: req_wr, addr: req_addr, data: req_data};
  end

  // NOTE: all sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Pop only looks at the registered count, so a freshly pushed entry waits one edge.
  // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    we_nxt        = 1'b0;
    rd_nxt        = 1'b0;
    addr_nxt      = sram_addr;
    din_nxt       = sram_din;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = rsp_data;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          addr_nxt = head.addr;
          if (head.wr) begin
            we_nxt  = 1'b1;
            din_nxt = head.data;
          end else begin
            rd_nxt    = 1'b1;
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: state_nxt = RD_CAP;
      RD_CAP: begin
        rsp_valid_nxt = 1'b1;
        rsp_data_nxt  = sram_dout;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sram_we   <= 1'b0;
      sram_rd   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nxt;
      sram_we   <= we_nxt;
      sram_rd   <= rd_nxt;
      sram_addr <= addr_nxt;
      sram_din  <= din_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
    end
  end

endmodule
